prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters:
- BASE, `INSTRUCTION_BASE, first address of the program region.
- DEPTH, `MEM_DEPTH, memory depth; the region is BASE..DEPTH-1 and LEN = DEPTH-BASE.
REQ-002 clk  in  1  system clock; phi2 domain, same clock as mem.
REQ-003 reset  in  1  one clock; reset is synchronous and active-high.
REQ-004 start  in  1  begin the load sequence.
REQ-005 src_valid  in  1  program byte available.
REQ-006 src_data  in  `REG_WIDTH  program byte.
REQ-007 src_last  in  1  accompanies the final program byte.
REQ-008 src_ready  out  1  loader accepts a byte this cycle.
REQ-009 mem_sel  out  1  1 = loader owns the mem addr/data/we ports.
REQ-010 mem_addr  out  `ADDR_WIDTH  mem address.
REQ-011 mem_we  out  1  mem write enable.
REQ-012 mem_dout  out  `REG_WIDTH  write data to mem.
REQ-013 mem_din  in  `REG_WIDTH  mem read data; valid one cycle after mem_addr is presented.
REQ-014 core_reset_n  out  1  active-low reset to fetcher, decoder, ALU and registers.
REQ-015 trigger  out  1  one-cycle get_next pulse to the fetcher.
REQ-016 busy, done, error  out  1 each  status flags.
REQ-017 err_code  out  2  01 = overflow, 10 = checksum mismatch.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, ZERO, LOAD, VERIFY, RELEASE, RUN, ERROR.
REQ-019 All outputs SHALL be registered; src_ready SHALL be 1 only in LOAD.
REQ-020 IDLE: start=1 SHALL move to ZERO on the next cycle.
REQ-021 ZERO: one write of 8'h00 per cycle to BASE..DEPTH-1 in ascending order (LEN cycles), then LOAD.
REQ-022 LOAD: each src_valid&src_ready byte SHALL be written to BASE+cnt.
- cnt SHALL then increment.
- The byte SHALL be added to a 16-bit modulo-2^16 checksum.
- src_valid=0 SHALL produce no write and no count change.
REQ-023 A byte accepted with src_last=1 SHALL be written, and the FSM SHALL go to VERIFY.
- Zero-length programs are impossible.
REQ-024 src_valid=1 while cnt==LEN SHALL NOT write; the FSM SHALL go to ERROR with err_code=01.
REQ-025 VERIFY: read addresses BASE..BASE+cnt-1 on consecutive cycles with mem_we=0.
- Accumulate mem_din one cycle later into a second checksum.
- Duration SHALL be cnt+1 cycles.
REQ-026 On a checksum match the FSM SHALL go to RELEASE; on a mismatch it SHALL go to ERROR with err_code=10.
REQ-027 RELEASE (one cycle): mem_sel=0 and core_reset_n=1. The next cycle SHALL enter RUN with trigger=1 for exactly one cycle.
REQ-028 RUN: done=1, mem_sel=0, core_reset_n=1.
REQ-029 start in RUN or ERROR SHALL re-enter ZERO. In the same cycle mem_sel=1, core_reset_n=0, done=0, error=0, err_code=00.
REQ-030 start in ZERO, LOAD, VERIFY or RELEASE SHALL be ignored.
REQ-031 ERROR: error=1, core_reset_n=0, mem_sel=1, no writes; held until start or reset.
REQ-032 busy SHALL be 1 in ZERO, LOAD, VERIFY and RELEASE.
REQ-033 core_reset_n SHALL be 0 in every state except RELEASE and RUN.
REQ-034 mem_addr SHALL hold its last value when idle.

Reset
REQ-035 On reset=1 at a clk edge, the FSM SHALL enter IDLE with:
- mem_sel=1, core_reset_n=0, mem_we=0, mem_addr=0, mem_dout=0.
- src_ready=0, trigger=0, busy=0, done=0, error=0, err_code=00.
- cnt=0 and both checksums=0.
REQ-036 Reset during any state, including mid-ZERO or mid-LOAD, SHALL abort with no further writes; outputs SHALL take reset values from the next cycle.

Structure
REQ-037 `ADDR_WIDTH, `REG_WIDTH, `INSTRUCTION_BASE, `MEM_DEPTH and the state/err_code encodings SHALL live in the shared PKG/pkg.v.
REQ-038 One sub-module SHALL be used: ld_checksum (16-bit accumulate with clear), instantiated twice (load and verify).
REQ-039 In tb_iflow the loader SHALL replace the manual_mem muxing; mem_sel drives the mux select.

Verification (BASE=16'h0200, DEPTH=16'h0210)
REQ-040 Reset, start, bytes A9,05,00 with last on 00:
- 16 zero writes to 0200..020F, then writes 0200=A9, 0201=05, 0202=00.
- VERIFY lasts 4 cycles.
- core_reset_n rises, one trigger pulse follows, done=1.
REQ-041 Same program with src_valid low on alternate cycles: identical mem contents, no extra writes, src_ready=1 throughout LOAD.
REQ-042 17 bytes with no last: 16 written, then error=1, err_code=01, core_reset_n stays 0, trigger never pulses.
REQ-043 Bench mem model returns 0201=06 on readback: error=1, err_code=10, mem_sel=1, no trigger.
REQ-044 reset asserted after the 2nd LOAD byte: next cycle all outputs at reset values, mem_we=0; start then re-zeroes 0200..020F.
REQ-045 start in RUN: same cycle core_reset_n=0, mem_sel=1, done=0; zeroing restarts at 0200.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared widths, memory map defaults, FSM/err_code encodings and checksum helper.
package prog_loader_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned CK_WIDTH   = 16;

    localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;
    localparam logic [ADDR_WIDTH-1:0] MEM_DEPTH        = 16'h0210;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ZERO    = 3'd1,
        LOAD    = 3'd2,
        VERIFY  = 3'd3,
        RELEASE = 3'd4,
        RUN     = 3'd5,
        ERROR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_OVERFLOW = 2'b01,
        ERR_CHECKSUM = 2'b10
    } err_code_t;

    // Modulo-2^16 accumulate of one program byte.
    function automatic logic [CK_WIDTH-1:0] ck_add(input logic [CK_WIDTH-1:0]  sum,
                                                    input logic [REG_WIDTH-1:0] data);
        return sum + CK_WIDTH'(data);
    endfunction

endpackage

// File: rtl/prog_loader_ld_checksum.sv
// 16-bit running byte checksum with synchronous clear.
module ld_checksum
    import prog_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [REG_WIDTH-1:0] data_i,
    output logic [CK_WIDTH-1:0]  sum_o
);

    logic [CK_WIDTH-1:0] sum_q;

    // Clear wins over accumulate so a restart always begins from zero.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= ck_add(sum_q, data_i);
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: zero the program region, stream bytes in, read back and
// checksum them, then release the core from reset and kick the fetcher.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE  = INSTRUCTION_BASE,
    parameter logic [ADDR_WIDTH-1:0] DEPTH = MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  src_valid,
    input  logic [REG_WIDTH-1:0]  src_data,
    input  logic                  src_last,
    output logic                  src_ready,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_dout,
    input  logic [REG_WIDTH-1:0]  mem_din,
    output logic                  core_reset_n,
    output logic                  trigger,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    // One extra bit so a completely full region (cnt == LEN) is representable.
    localparam int unsigned           CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  LEN       = CNT_WIDTH'(DEPTH) - CNT_WIDTH'(BASE);

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  vcnt_q;
    logic                  last_q;
    logic                  src_ready_q;
    logic                  mem_sel_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [REG_WIDTH-1:0]  mem_dout_q;
    logic                  core_reset_n_q;
    logic                  trigger_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    err_code_t             err_code_q;

    logic                  go_zero_c;
    logic                  accept_c;
    logic                  vf_en_c;
    logic [CK_WIDTH-1:0]   ld_sum;
    logic [CK_WIDTH-1:0]   vf_sum;
    logic [CK_WIDTH-1:0]   vf_total_c;

    // Handshake, restart and readback control decoded from the current state.
    always_comb begin
        go_zero_c  = start && (state_q inside {IDLE, RUN, ERROR});
        accept_c   = (state_q == LOAD) && src_ready_q && src_valid && (cnt_q != LEN);
        vf_en_c    = (state_q == VERIFY) && (vcnt_q != '0);
        vf_total_c = ck_add(vf_sum, mem_din);
    end

    ld_checksum u_ck_load (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (go_zero_c),
        .en_i   (accept_c),
        .data_i (src_data),
        .sum_o  (ld_sum)
    );

    ld_checksum u_ck_verify (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (go_zero_c),
        .en_i   (vf_en_c),
        .data_i (mem_din),
        .sum_o  (vf_sum)
    );

    // Loader FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            vcnt_q         <= '0;
            last_q         <= 1'b0;
            src_ready_q    <= 1'b0;
            mem_sel_q      <= 1'b1;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_dout_q     <= '0;
            core_reset_n_q <= 1'b0;
            trigger_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            trigger_q <= 1'b0;
            mem_we_q  <= 1'b0;

            if (go_zero_c) begin
                state_q        <= ZERO;
                cnt_q          <= '0;
                vcnt_q         <= '0;
                last_q         <= 1'b0;
                src_ready_q    <= 1'b0;
                mem_sel_q      <= 1'b1;
                mem_addr_q     <= BASE;
                mem_we_q       <= 1'b1;
                mem_dout_q     <= '0;
                core_reset_n_q <= 1'b0;
                busy_q         <= 1'b1;
                done_q         <= 1'b0;
                error_q        <= 1'b0;
                err_code_q     <= ERR_NONE;
            end else begin
                case (state_q)
                    ZERO: begin
                        if (cnt_q == LEN - CNT_WIDTH'(1)) begin
                            state_q     <= LOAD;
                            cnt_q       <= '0;
                            src_ready_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + CNT_WIDTH'(1);
                            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                            mem_dout_q <= '0;
                            mem_we_q   <= 1'b1;
                        end
                    end

                    LOAD: begin
                        if (last_q) begin
                            // Final byte's write cycle has completed; start readback.
                            state_q    <= VERIFY;
                            last_q     <= 1'b0;
                            vcnt_q     <= '0;
                            mem_addr_q <= BASE;
                        end else if (src_valid) begin
                            if (cnt_q == LEN) begin
                                state_q     <= ERROR;
                                src_ready_q <= 1'b0;
                                busy_q      <= 1'b0;
                                error_q     <= 1'b1;
                                err_code_q  <= ERR_OVERFLOW;
                            end else begin
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= BASE + cnt_q[ADDR_WIDTH-1:0];
                                mem_dout_q <= src_data;
                                cnt_q      <= cnt_q + CNT_WIDTH'(1);
                                if (src_last) begin
                                    last_q      <= 1'b1;
                                    src_ready_q <= 1'b0;
                                end
                            end
                        end
                    end

                    VERIFY: begin
                        if (vcnt_q == cnt_q) begin
                            if (vf_total_c == ld_sum) begin
                                state_q        <= RELEASE;
                                mem_sel_q      <= 1'b0;
                                core_reset_n_q <= 1'b1;
                            end else begin
                                state_q    <= ERROR;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                                err_code_q <= ERR_CHECKSUM;
                            end
                        end else begin
                            vcnt_q <= vcnt_q + CNT_WIDTH'(1);
                            if (vcnt_q + CNT_WIDTH'(1) < cnt_q) begin
                                mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end

                    RELEASE: begin
                        state_q   <= RUN;
                        trigger_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end

                    default: begin
                        // IDLE, RUN and ERROR hold until start or reset.
                    end
                endcase
            end
        end
    end

    assign src_ready    = src_ready_q;
    assign mem_sel      = mem_sel_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_dout     = mem_dout_q;
    assign core_reset_n = core_reset_n_q;
    assign trigger      = trigger_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: memory model, write scoreboard and scenario tasks.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        src_valid;
    logic [7:0]  src_data;
    logic        src_last;
    logic        src_ready;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        core_reset_n;
    logic        trigger;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q[$];
    int          trig_cnt = 0;
    bit          cr_high_seen = 1'b0;
    bit          corrupt = 1'b0;
    logic [7:0]  prog [0:31];
    logic [7:0]  mem  [0:16'h020F];
    logic [7:0]  rd_q;

    prog_loader #(.BASE(16'h0200), .DEPTH(16'h0210)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .core_reset_n (core_reset_n),
        .trigger      (trigger),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Synchronous memory: one-cycle read latency, optional corrupted readback of 0201.
    always @(posedge clk) begin
        if (mem_we === 1'b1 && mem_sel === 1'b1 && mem_addr <= 16'h020F)
            mem[mem_addr] <= mem_dout;
        if (corrupt && mem_addr == 16'h0201)
            rd_q <= 8'h06;
        else if (mem_addr <= 16'h020F)
            rd_q <= mem[mem_addr];
        else
            rd_q <= 8'h00;
    end
    assign mem_din = rd_q;

    // Write scoreboard and event monitor.
    always @(negedge clk) begin
        logic [23:0] e;
        if (trigger === 1'b1) trig_cnt++;
        if (core_reset_n === 1'b1) cr_high_seen = 1'b1;
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got=%h_%h want=none", mem_addr, mem_dout);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_dout} !== e) begin
                    bad++;
                    $display("FAIL wr_order got=%h want=%h", {mem_addr, mem_dout}, e);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_last = 1'b0; src_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_zero();
        for (int i = 0; i < 16; i++) exp_q.push_back({16'h0200 + 16'(i), 8'h00});
    endtask

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({16'h0200 + 16'(i), prog[i]});
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (src_ready !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic feed(input int n, input bit gap, input bit use_last, output int nr);
        nr = 0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                if (src_ready !== 1'b1) nr++;
                src_valid = 1'b0; src_last = 1'b0;
                @(negedge clk);
            end
            if (src_ready !== 1'b1) nr++;
            src_valid = 1'b1; src_data = prog[i]; src_last = use_last && (i == n - 1);
            @(negedge clk);
        end
        src_valid = 1'b0; src_last = 1'b0;
    endtask

    task automatic wait_release(output int v);
        v = 0;
        while (core_reset_n !== 1'b1 && error !== 1'b1 && v < 100) begin
            @(negedge clk);
            v++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({mem_sel, core_reset_n, mem_we, src_ready, trigger, busy, done, error, err_code} !== 10'b1_0_0_0_0_0_0_0_00) begin
            bad++;
            $display("FAIL reset_flags got=%b want=%b",
                     {mem_sel, core_reset_n, mem_we, src_ready, trigger, busy, done, error, err_code}, 10'b1000000000);
        end
        total++;
        if ({mem_addr, mem_dout} !== 24'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h want=000000", {mem_addr, mem_dout});
        end
    endtask

    task automatic test_basic();
        int c, nr, bv, bm;
        do_reset();
        exp_q.delete(); trig_cnt = 0; cr_high_seen = 1'b0;
        prog[0] = 8'hA9; prog[1] = 8'h05; prog[2] = 8'h00;
        push_zero(); push_prog(3);
        kick();
        total++;
        if ({busy, mem_sel, core_reset_n, mem_we, mem_addr} !== {4'b1101, 16'h0200}) begin
            bad++;
            $display("FAIL zero_first got=%b_%h want=1101_0200", {busy, mem_sel, core_reset_n, mem_we}, mem_addr);
        end
        wait_ready(c);
        total++;
        if (c !== 16) begin bad++; $display("FAIL zero_len got=%0d want=16", c); end
        feed(3, 1'b0, 1'b1, nr);
        total++;
        if (nr !== 0) begin bad++; $display("FAIL load_ready got=%0d want=0", nr); end
        bv = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we !== 1'b0 || core_reset_n !== 1'b0 || busy !== 1'b1) bv++;
            if (k < 3 && mem_addr !== 16'h0200 + 16'(k)) bv++;
        end
        total++;
        if (bv !== 0) begin bad++; $display("FAIL verify_phase got=%0d want=0", bv); end
        @(negedge clk);
        total++;
        if ({core_reset_n, mem_sel, trigger, busy, done} !== 5'b10010) begin
            bad++;
            $display("FAIL release got=%b want=10010", {core_reset_n, mem_sel, trigger, busy, done});
        end
        @(negedge clk);
        total++;
        if ({core_reset_n, mem_sel, trigger, busy, done, error} !== 6'b101010) begin
            bad++;
            $display("FAIL run_entry got=%b want=101010", {core_reset_n, mem_sel, trigger, busy, done, error});
        end
        @(negedge clk);
        total++;
        if ({trigger, done} !== 2'b01) begin bad++; $display("FAIL run_hold got=%b want=01", {trigger, done}); end
        repeat (3) @(negedge clk);
        total++;
        if (trig_cnt !== 1) begin bad++; $display("FAIL trig_count got=%0d want=1", trig_cnt); end
        bm = 0;
        for (int i = 0; i < 3; i++) if (mem[16'h0200 + 16'(i)] !== prog[i]) bm++;
        for (int i = 3; i < 16; i++) if (mem[16'h0200 + 16'(i)] !== 8'h00) bm++;
        total++;
        if (bm !== 0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL basic_mem got=%0d/%0d want=0/0", bm, exp_q.size());
        end
    endtask

    task automatic test_restart_in_run();
        int c, nr, v, bm;
        exp_q.delete(); trig_cnt = 0;
        push_zero(); push_prog(3);
        kick();
        total++;
        if ({core_reset_n, mem_sel, done, error, err_code, busy, mem_we, mem_addr} !== {8'b0_1_0_0_00_1_1, 16'h0200}) begin
            bad++;
            $display("FAIL restart_entry got=%b_%h want=01000011_0200",
                     {core_reset_n, mem_sel, done, error, err_code, busy, mem_we}, mem_addr);
        end
        wait_ready(c);
        total++;
        if (c !== 16) begin bad++; $display("FAIL restart_zero_len got=%0d want=16", c); end
        feed(3, 1'b1, 1'b1, nr);
        total++;
        if (nr !== 0) begin bad++; $display("FAIL gap_ready got=%0d want=0", nr); end
        wait_release(v);
        total++;
        if (v - 1 !== 4 || core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL gap_verify got=%0d/%b want=4/1", v - 1, core_reset_n);
        end
        repeat (3) @(negedge clk);
        bm = 0;
        for (int i = 0; i < 3; i++) if (mem[16'h0200 + 16'(i)] !== prog[i]) bm++;
        total++;
        if (bm !== 0 || exp_q.size() !== 0 || trig_cnt !== 1 || done !== 1'b1) begin
            bad++;
            $display("FAIL gap_result got=%0d/%0d/%0d/%b want=0/0/1/1", bm, exp_q.size(), trig_cnt, done);
        end
    endtask

    task automatic test_overflow();
        int c, nr;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 17; i++) prog[i] = 8'($urandom_range(1, 255));
        push_zero(); push_prog(16);
        trig_cnt = 0; cr_high_seen = 1'b0;
        kick();
        wait_ready(c);
        feed(17, 1'b0, 1'b0, nr);
        total++;
        if ({error, err_code, core_reset_n, mem_sel, busy, src_ready, mem_we} !== 8'b1_01_0_1_0_0_0) begin
            bad++;
            $display("FAIL ovf_entry got=%b want=10101000",
                     {error, err_code, core_reset_n, mem_sel, busy, src_ready, mem_we});
        end
        repeat (5) @(negedge clk);
        total++;
        if ({error, err_code} !== 3'b101 || trig_cnt !== 0 || cr_high_seen !== 1'b0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL ovf_hold got=%b/%0d/%b/%0d want=101/0/0/0",
                     {error, err_code}, trig_cnt, cr_high_seen, exp_q.size());
        end
    endtask

    task automatic test_checksum_err();
        int c, nr, v;
        do_reset();
        exp_q.delete();
        prog[0] = 8'hA9; prog[1] = 8'h05; prog[2] = 8'h00;
        corrupt = 1'b1;
        push_zero(); push_prog(3);
        trig_cnt = 0; cr_high_seen = 1'b0;
        kick();
        wait_ready(c);
        feed(3, 1'b0, 1'b1, nr);
        wait_release(v);
        total++;
        if (v - 1 !== 4 || {error, err_code, mem_sel, core_reset_n, busy, done} !== 7'b1_10_1_0_0_0) begin
            bad++;
            $display("FAIL ck_err got=%0d/%b want=4/1101000",
                     v - 1, {error, err_code, mem_sel, core_reset_n, busy, done});
        end
        repeat (3) @(negedge clk);
        total++;
        if (trig_cnt !== 0 || cr_high_seen !== 1'b0 || error !== 1'b1 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL ck_hold got=%0d/%b/%b/%0d want=0/0/1/0", trig_cnt, cr_high_seen, error, exp_q.size());
        end
        corrupt = 1'b0;
        push_zero();
        kick();
        total++;
        if ({error, err_code, busy, mem_we, mem_sel, core_reset_n, mem_addr} !== {7'b0_00_1_1_1_0, 16'h0200}) begin
            bad++;
            $display("FAIL err_restart got=%b_%h want=0001110_0200",
                     {error, err_code, busy, mem_we, mem_sel, core_reset_n}, mem_addr);
        end
        do_reset();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        int c, nr, bm;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) prog[i] = 8'($urandom_range(1, 255));
        push_zero(); push_prog(2);
        kick();
        wait_ready(c);
        feed(2, 1'b0, 1'b0, nr);
        reset = 1'b1; src_valid = 1'b1; src_data = prog[2];
        @(negedge clk);
        total++;
        if ({mem_sel, core_reset_n, mem_we, src_ready, trigger, busy, done, error, err_code, mem_addr, mem_dout}
            !== {10'b1000000000, 24'h0}) begin
            bad++;
            $display("FAIL midload_reset got=%b_%h_%h want=1000000000_0000_00",
                     {mem_sel, core_reset_n, mem_we, src_ready, trigger, busy, done, error, err_code}, mem_addr, mem_dout);
        end
        reset = 1'b0; src_valid = 1'b0;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL midload_quiet got=%b/%0d want=0/0", mem_we, exp_q.size());
        end
        push_zero();
        kick();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(c);
        total++;
        if (c !== 11) begin bad++; $display("FAIL start_ignored got=%0d want=11", c); end
        bm = 0;
        for (int i = 0; i < 16; i++) if (mem[16'h0200 + 16'(i)] !== 8'h00) bm++;
        total++;
        if (bm !== 0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rezero got=%0d/%0d want=0/0", bm, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart_in_run();
        test_overflow();
        test_checksum_err();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
